song_sequencer: RTL and testbench

- Parametrised next-generation note sequencer. Walks a song ROM one note at a time and hands each note/duration pair to note_player through a new_note / note_done handshake.
- Generalised over song count, notes per song, field widths and ROM read latency.
- ROM is external (address out, data in). Adds an in-band end-of-song marker, clean song switching and a registered song_done pulse.
- Sits between the top-level controls (play, song select) and note_player.

---
 rtl/song_pkg.sv | 37 +++
 rtl/song_sequencer_latency_counter.sv | 54 +++++
 rtl/song_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_song_sequencer.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/song_pkg.sv
// ---------------------------------------------------------------------------
// song_pkg
// Shared definitions for the song sequencer slice: the sequencer state
// encoding, the in-band end-of-song marker, the default field widths and a
// helper that sizes the ROM latency counter.
// No ports (package).
// ---------------------------------------------------------------------------
package song_pkg;

    // Sequencer states. PAUSE is the reset state.
    typedef enum logic [2:0] {
        PAUSE     = 3'd0,
        FETCH     = 3'd1,
        ISSUE     = 3'd2,
        WAIT_DONE = 3'd3,
        ADVANCE   = 3'd4,
        DONE      = 3'd5
    } seq_state_e;

    // Default field widths and ROM read latency.
    localparam int DEF_SONG_W      = 2;
    localparam int DEF_NOTE_ADDR_W = 5;
    localparam int DEF_NOTE_W      = 6;
    localparam int DEF_DUR_W       = 6;
    localparam int DEF_ROM_LAT     = 1;

    // A ROM entry whose duration field equals this value ends the song.
    localparam int END_MARKER_DUR = 0;

    // Width needed to count from 0 up to and including 'lat'.
    function automatic int lat_cnt_w(input int lat);
        int w;
        w = $clog2(lat + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/song_sequencer_latency_counter.sv
// ---------------------------------------------------------------------------
// seq_latency_counter
// Counts the cycles spent waiting for the external song ROM. The count is
// cleared by load_i, advances while en_i is high and saturates at ROM_LAT,
// where tc_o flags that rom_data now reflects the current rom_addr.
//
// Ports:
//   clk     in   system clock, rising edge
//   reset   in   asynchronous active-low clear
//   load_i  in   restart the count at zero (wins over en_i)
//   en_i    in   advance the count by one per cycle
//   tc_o    out  count has reached ROM_LAT
// ---------------------------------------------------------------------------
module seq_latency_counter
    import song_pkg::*;
#(
    parameter int ROM_LAT = DEF_ROM_LAT,
    parameter int CNT_W   = lat_cnt_w(ROM_LAT)
)
(
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic en_i,
    output logic tc_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Terminal count: the ROM has had ROM_LAT full cycles to answer.
    assign tc_o = (cnt_q == CNT_W'(ROM_LAT));

    // Next count: load restarts from zero, otherwise step until the terminal
    // count and then hold there so tc_o stays asserted until the next load.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (en_i && !tc_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/song_sequencer.sv
// ---------------------------------------------------------------------------
// song_sequencer
// Walks an external song ROM one entry at a time and hands each
// note/duration pair to note_player through a new_note / note_done
// handshake. A ROM entry with a zero duration ends the song early; a song
// that fills every slot ends after its last slot. Switching songs restarts
// playback from entry 0 of the new song without a song_done pulse.
//
// Optional feature (macro SONG_SEQ_LOOP_EN): adds input 'loop'. With loop=1
// the end of a song pulses song_done and restarts the same song from entry 0
// instead of holding in DONE.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   play       in   level, 1 = run, 0 = pause
//   song       in   song select
//   note_done  in   single-cycle pulse: note_player finished the note
//   loop       in   (SONG_SEQ_LOOP_EN only) restart the song at its end
//   rom_addr   out  {cur_song, note_idx}, registered
//   rom_data   in   {note, duration}, valid ROM_LAT cycles after rom_addr
//   new_note   out  single-cycle pulse, note/duration valid with it
//   note       out  registered note code
//   duration   out  registered duration
//   song_done  out  registered single-cycle end-of-song pulse
//   note_idx   out  current note index
// ---------------------------------------------------------------------------
module song_sequencer
    import song_pkg::*;
#(
    parameter int SONG_W      = DEF_SONG_W,
    parameter int NOTE_ADDR_W = DEF_NOTE_ADDR_W,
    parameter int NOTE_W      = DEF_NOTE_W,
    parameter int DUR_W       = DEF_DUR_W,
    parameter int ROM_LAT     = DEF_ROM_LAT
)
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          play,
    input  logic [SONG_W-1:0]             song,
    input  logic                          note_done,
`ifdef SONG_SEQ_LOOP_EN
    input  logic                          loop,
`endif
    output logic [SONG_W+NOTE_ADDR_W-1:0] rom_addr,
    input  logic [NOTE_W+DUR_W-1:0]       rom_data,
    output logic                          new_note,
    output logic [NOTE_W-1:0]             note,
    output logic [DUR_W-1:0]              duration,
    output logic                          song_done,
    output logic [NOTE_ADDR_W-1:0]        note_idx
);

    seq_state_e             state_q;
    seq_state_e             state_d;
    logic [SONG_W-1:0]      cur_song_q;
    logic [SONG_W-1:0]      cur_song_d;
    logic [NOTE_ADDR_W-1:0] idx_q;
    logic [NOTE_ADDR_W-1:0] idx_d;
    logic [NOTE_W-1:0]      note_q;
    logic [NOTE_W-1:0]      note_d;
    logic [DUR_W-1:0]       dur_q;
    logic [DUR_W-1:0]       dur_d;
    logic                   song_done_q;
    logic                   song_done_d;

    logic                   lat_load;
    logic                   lat_en;
    logic                   lat_tc;
    logic                   song_change;
    logic                   end_song;
    logic                   loop_req;
    logic [NOTE_W-1:0]      rom_note;
    logic [DUR_W-1:0]       rom_dur;

    assign rom_note = rom_data[NOTE_W+DUR_W-1:DUR_W];
    assign rom_dur  = rom_data[DUR_W-1:0];

`ifdef SONG_SEQ_LOOP_EN
    assign loop_req = loop;
`else
    assign loop_req = 1'b0;
`endif

    // The selected song is sampled every cycle. In PAUSE this simply tracks
    // the selector; elsewhere a difference between song and cur_song_q is
    // exactly the song-change event, and the same edge adopts the new song.
    assign cur_song_d  = song;
    assign song_change = (state_q != PAUSE) && (song != cur_song_q);

    // The ROM wait counter only runs while fetching.
    assign lat_en = (state_q == FETCH);

    seq_latency_counter #(
        .ROM_LAT (ROM_LAT)
    ) u_lat_cnt (
        .clk    (clk),
        .reset  (reset),
        .load_i (lat_load),
        .en_i   (lat_en),
        .tc_o   (lat_tc)
    );

    // Next-state logic. Priority is play=0, then a song change, then the
    // per-state behaviour (which is where note_done is consumed). Pausing
    // keeps note_idx so resume re-fetches and replays the current note.
    // An end marker leaves note/duration showing the last real note.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        note_d      = note_q;
        dur_d       = dur_q;
        song_done_d = 1'b0;
        lat_load    = 1'b0;
        end_song    = 1'b0;

        if (state_q != PAUSE && !play) begin
            state_d = PAUSE;
            if (song_change) begin
                idx_d = '0;
            end
        end else if (song_change) begin
            idx_d    = '0;
            state_d  = FETCH;
            lat_load = 1'b1;
        end else begin
            case (state_q)
                PAUSE: begin
                    if (play) begin
                        state_d  = FETCH;
                        lat_load = 1'b1;
                    end
                end
                FETCH: begin
                    if (lat_tc) begin
                        if (rom_dur == DUR_W'(END_MARKER_DUR)) begin
                            end_song = 1'b1;
                        end else begin
                            note_d  = rom_note;
                            dur_d   = rom_dur;
                            state_d = ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    state_d = WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (note_done) begin
                        state_d = ADVANCE;
                    end
                end
                ADVANCE: begin
                    // The last slot ends the song rather than wrapping.
                    if (idx_q == {NOTE_ADDR_W{1'b1}}) begin
                        end_song = 1'b1;
                    end else begin
                        idx_d    = idx_q + 1'b1;
                        state_d  = FETCH;
                        lat_load = 1'b1;
                    end
                end
                DONE: begin
                    idx_d = '0;
                end
                default: begin
                    state_d = PAUSE;
                end
            endcase

            // Both ways of finishing a song meet here: pulse song_done,
            // rewind, then either hold in DONE or restart when looping.
            if (end_song) begin
                song_done_d = 1'b1;
                idx_d       = '0;
                if (loop_req) begin
                    state_d  = FETCH;
                    lat_load = 1'b1;
                end else begin
                    state_d = DONE;
                end
            end
        end
    end

    // State, song, index, note fields and song_done pulse registers, all
    // cleared asynchronously so no partial pulse survives a reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= PAUSE;
            cur_song_q  <= '0;
            idx_q       <= '0;
            note_q      <= '0;
            dur_q       <= '0;
            song_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_song_q  <= cur_song_d;
            idx_q       <= idx_d;
            note_q      <= note_d;
            dur_q       <= dur_d;
            song_done_q <= song_done_d;
        end
    end

    assign rom_addr  = {cur_song_q, idx_q};
    assign new_note  = (state_q == ISSUE);
    assign note      = note_q;
    assign duration  = dur_q;
    assign song_done = song_done_q;
    assign note_idx  = idx_q;

endmodule

// File: tb/tb_song_sequencer.sv
// ---------------------------------------------------------------------------
// tb_song_sequencer
// Self-checking bench for song_sequencer. A main instance (ROM_LAT=1) is
// driven through basic playback, a full 32-note song, pause/resume, a song
// change racing note_done and a reset during ISSUE; a second instance with
// ROM_LAT=3 checks fetch latency. Expected new_note/song_done events are
// queued by the stimulus and popped by an independent monitor.
// ---------------------------------------------------------------------------
module tb_song_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       play;
    logic [1:0] song;
    logic       noteDone;
    logic [6:0] romAddr;
    logic [11:0] romData;
    logic       newNote;
    logic [5:0] note;
    logic [5:0] duration;
    logic       songDone;
    logic [4:0] noteIdx;

    logic       play3;
    logic       noteDone3;
    logic [6:0] romAddr3;
    logic [11:0] romData3;
    logic       newNote3;
    logic [5:0] note3;
    logic [5:0] duration3;
    logic       songDone3;
    logic [4:0] noteIdx3;

    logic [11:0] romMem [0:127];
    logic [11:0] pipe3a;
    logic [11:0] pipe3b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit isDone;
        int noteVal;
        int durVal;
        int idxVal;
    } ev_t;

    ev_t sb[$];
    ev_t monEv;

    song_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .play      (play),
        .song      (song),
        .note_done (noteDone),
`ifdef SONG_SEQ_LOOP_EN
        .loop      (1'b0),
`endif
        .rom_addr  (romAddr),
        .rom_data  (romData),
        .new_note  (newNote),
        .note      (note),
        .duration  (duration),
        .song_done (songDone),
        .note_idx  (noteIdx)
    );

    song_sequencer #(.ROM_LAT(3)) dut3 (
        .clk       (clk),
        .reset     (reset),
        .play      (play3),
        .song      (2'd0),
        .note_done (noteDone3),
`ifdef SONG_SEQ_LOOP_EN
        .loop      (1'b0),
`endif
        .rom_addr  (romAddr3),
        .rom_data  (romData3),
        .new_note  (newNote3),
        .note      (note3),
        .duration  (duration3),
        .song_done (songDone3),
        .note_idx  (noteIdx3)
    );

    // ROM models: one registered stage for the main instance, three for the
    // latency instance, both reading the same contents.
    always @(posedge clk) begin
        romData <= romMem[romAddr];
        pipe3a  <= romMem[romAddr3];
        pipe3b  <= pipe3a;
        romData3 <= pipe3b;
    end

    function automatic logic [11:0] romWord(input int n, input int d);
        logic [31:0] nv;
        logic [31:0] dv;
        nv = n;
        dv = d;
        return {nv[5:0], dv[5:0]};
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: got no event within the cycle budget, expected one", name);
    endtask

    task automatic pushNote(input int n, input int d, input int i);
        ev_t e;
        e.isDone  = 1'b0;
        e.noteVal = n;
        e.durVal  = d;
        e.idxVal  = i;
        sb.push_back(e);
    endtask

    task automatic pushDone();
        ev_t e;
        e.isDone  = 1'b1;
        e.noteVal = 0;
        e.durVal  = 0;
        e.idxVal  = 0;
        sb.push_back(e);
    endtask

    task automatic applyStimulus(input logic p, input logic [1:0] s);
        @(posedge clk);
        #1;
        play = p;
        song = s;
    endtask

    task automatic waitNewNote(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!newNote && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!newNote) timeoutFail(tag);
    endtask

    task automatic waitSongDone(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!songDone && n < 80) begin
            @(negedge clk);
            n++;
        end
        if (!songDone) timeoutFail(tag);
    endtask

    task automatic pulseNoteDone();
        @(posedge clk);
        #1;
        noteDone = 1'b1;
        @(posedge clk);
        #1;
        noteDone = 1'b0;
    endtask

    task automatic playNote(input string tag);
        waitNewNote(tag);
        pulseNoteDone();
    endtask

    // Monitor: every new_note or song_done pulse must match the oldest
    // queued expectation; a pulse with nothing queued is a failure.
    always @(negedge clk) begin
        if (reset && (newNote || songDone)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_event: got new_note=%0b song_done=%0b, expected no event",
                         newNote, songDone);
            end else begin
                monEv = sb.pop_front();
                checkOutput("event_is_song_done", int'(songDone), int'(monEv.isDone));
                if (!monEv.isDone) begin
                    checkOutput("event_note", int'(note), monEv.noteVal);
                    checkOutput("event_duration", int'(duration), monEv.durVal);
                    checkOutput("event_note_idx", int'(noteIdx), monEv.idxVal);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got time limit, expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        int cnt;
        reset     = 1'b0;
        play      = 1'b0;
        song      = 2'd0;
        noteDone  = 1'b0;
        play3     = 1'b0;
        noteDone3 = 1'b0;

        // Song 0: 5/3, 9/2, end. Song 1: 32 entries. Song 2: 20/4, 21/5, end.
        // Song 3: 1/1, 2/2, 3/3, 4/4, end.
        for (int a = 0; a < 128; a++) romMem[a] = 12'd0;
        romMem[0] = romWord(5, 3);
        romMem[1] = romWord(9, 2);
        for (int i = 0; i < 32; i++) romMem[32 + i] = romWord(i + 1, (i % 5) + 1);
        romMem[64] = romWord(20, 4);
        romMem[65] = romWord(21, 5);
        for (int i = 0; i < 4; i++) romMem[96 + i] = romWord(i + 1, i + 1);

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_rom_addr", int'(romAddr), 0);
        checkOutput("rst_note", int'(note), 0);
        checkOutput("rst_duration", int'(duration), 0);
        checkOutput("rst_new_note", int'(newNote), 0);
        checkOutput("rst_song_done", int'(songDone), 0);
        checkOutput("rst_note_idx", int'(noteIdx), 0);
        reset = 1'b1;

        // Basic playback of song 0.
        $display("[TB] basic playback");
        pushNote(5, 3, 0);
        pushNote(9, 2, 1);
        pushDone();
        applyStimulus(1'b1, 2'd0);
        playNote("basic_note1");
        playNote("basic_note2");
        waitSongDone("basic_song_done");
        repeat (5) @(negedge clk);
        checkOutput("basic_idx_hold", int'(noteIdx), 0);
        checkOutput("basic_note_hold", int'(note), 9);
        checkOutput("basic_dur_hold", int'(duration), 2);

        // Full 32-slot song with no end marker.
        $display("[TB] full song");
        for (int i = 0; i < 32; i++) pushNote(i + 1, (i % 5) + 1, i);
        pushDone();
        applyStimulus(1'b1, 2'd1);
        for (int i = 0; i < 31; i++) playNote("full_note");
        playNote("full_note32");
        @(negedge clk);
        checkOutput("full_advance_idx", int'(noteIdx), 31);
        checkOutput("full_advance_song_done", int'(songDone), 0);
        @(negedge clk);
        checkOutput("full_song_done", int'(songDone), 1);
        checkOutput("full_done_idx", int'(noteIdx), 0);
        repeat (3) @(negedge clk);
        checkOutput("full_idx_no_wrap", int'(noteIdx), 0);

        // Pause during note 3 and resume: note 3 replays from index 2.
        $display("[TB] pause and resume");
        pushNote(1, 1, 0);
        pushNote(2, 2, 1);
        pushNote(3, 3, 2);
        pushNote(3, 3, 2);
        pushNote(4, 4, 3);
        pushDone();
        applyStimulus(1'b1, 2'd3);
        playNote("pause_note1");
        playNote("pause_note2");
        waitNewNote("pause_note3");
        applyStimulus(1'b0, 2'd3);
        repeat (9) @(posedge clk);
        @(negedge clk);
        checkOutput("pause_idx_kept", int'(noteIdx), 2);
        checkOutput("pause_rom_addr", int'(romAddr), 98);
        applyStimulus(1'b1, 2'd3);
        playNote("pause_note3_replay");
        playNote("pause_note4");
        waitSongDone("pause_song_done");

        // Song change 1 -> 2 in WAIT_DONE with note_done in the same cycle.
        $display("[TB] song change");
        pushNote(1, 1, 0);
        pushNote(20, 4, 0);
        pushNote(21, 5, 1);
        pushDone();
        applyStimulus(1'b1, 2'd1);
        waitNewNote("change_song1_note1");
        @(posedge clk);
        #1;
        song     = 2'd2;
        noteDone = 1'b1;
        @(posedge clk);
        #1;
        noteDone = 1'b0;
        @(negedge clk);
        checkOutput("change_rom_addr", int'(romAddr), 64);
        checkOutput("change_idx", int'(noteIdx), 0);
        playNote("change_song2_note1");
        playNote("change_song2_note2");
        waitSongDone("change_song_done");

        // Asynchronous reset while new_note is high.
        $display("[TB] reset during issue");
        pushNote(5, 3, 0);
        applyStimulus(1'b1, 2'd0);
        waitNewNote("reset_issue");
        #1;
        reset = 1'b0;
        #1;
        checkOutput("areset_new_note", int'(newNote), 0);
        checkOutput("areset_note", int'(note), 0);
        checkOutput("areset_duration", int'(duration), 0);
        checkOutput("areset_rom_addr", int'(romAddr), 0);
        checkOutput("areset_note_idx", int'(noteIdx), 0);
        checkOutput("areset_song_done", int'(songDone), 0);
        play = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("post_reset_new_note", int'(newNote), 0);

        // ROM_LAT=3: new_note four cycles after rom_addr moves.
        $display("[TB] ROM latency 3");
        @(posedge clk);
        #1;
        play3 = 1'b1;
        cnt = 0;
        @(negedge clk);
        while (!newNote3 && cnt < 60) begin
            @(negedge clk);
            cnt++;
        end
        if (!newNote3) timeoutFail("lat3_note1");
        checkOutput("lat3_note1", int'(note3), 5);
        checkOutput("lat3_dur1", int'(duration3), 3);
        @(posedge clk);
        #1;
        noteDone3 = 1'b1;
        @(posedge clk);
        #1;
        noteDone3 = 1'b0;
        cnt = 0;
        @(negedge clk);
        while (romAddr3 != 7'd1 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        if (romAddr3 != 7'd1) timeoutFail("lat3_addr_update");
        cnt = 0;
        while (!newNote3 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput("lat3_issue_delay", cnt, 4);
        checkOutput("lat3_note2", int'(note3), 9);
        checkOutput("lat3_dur2", int'(duration3), 2);

        repeat (4) @(negedge clk);
        checkOutput("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
